div_seq_arb: RTL

Multi-cycle shared integer divider. It arbitrates between two requesters using round-robin and sequences an unsigned restoring division, one quotient bit per cycle. It returns the quotient, the remainder, the requester id and a divide-by-zero flag over a valid/ready response channel. It sits beside the ALU and replaces a wide combinational divide with an N-cycle iterative unit that two clients share.

---
 rtl/div_seq_arb_if.sv | 34 +++
 rtl/div_seq_arb.sv | 121 ++++++++++++
 2 files changed

// File: rtl/div_seq_arb_if.sv
// Request/response bundle for the shared divider: two requesters in, one result channel out.
// The divider uses the slave modport; requesters and the result consumer use master.
interface div_seq_arb_if #(parameter int N = 16);
    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_dividend;
    logic [N-1:0] req0_divisor;
    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_dividend;
    logic [N-1:0] req1_divisor;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [N-1:0] rsp_quot;
    logic [N-1:0] rsp_rem;
    logic         rsp_dbz;

    modport slave (
        input  req0_valid, req0_dividend, req0_divisor,
        input  req1_valid, req1_dividend, req1_divisor,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz
    );

    modport master (
        output req0_valid, req0_dividend, req0_divisor,
        output req1_valid, req1_dividend, req1_divisor,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz
    );
endinterface

// File: rtl/div_seq_arb.sv
// Shared round-robin arbitrated restoring divider, one quotient bit per cycle.
// Latency: N CALC cycles after accept (divide-by-zero: result right after accept).
// Backpressure: result held in DONE until rsp_ready; no request accepted outside IDLE.
module div_seq_arb #(
    parameter int N = 16
) (
    input  logic          clk,
    input  logic          rst,
    div_seq_arb_if.slave  bus,
    output logic          busy
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    logic [N-1:0]  q;
    logic [N-1:0]  d;
    // Partial remainder always ends below the divisor, so N bits hold it; the
    // extra sign bit only exists in the trial subtraction below.
    logic [N-1:0]  r;
    logic [CW-1:0] cnt;
    logic          last;
    logic          id;

    logic          grant;
    logic          rdy0;
    logic          rdy1;
    logic          accept;
    logic [N-1:0]  acc_dividend;
    logic [N-1:0]  acc_divisor;
    logic [N:0]    shifted;
    logic [N:0]    trial;
    logic [N-1:0]  r_nxt;
    logic [N-1:0]  q_nxt;

    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid)
            grant = ~last;
        else if (bus.req1_valid)
            grant = 1'b1;
    end

    assign rdy0           = (state == IDLE) && bus.req0_valid && !grant;
    assign rdy1           = (state == IDLE) && bus.req1_valid && grant;
    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign accept         = rdy0 || rdy1;
    assign acc_dividend   = grant ? bus.req1_dividend : bus.req0_dividend;
    assign acc_divisor    = grant ? bus.req1_divisor  : bus.req0_divisor;

    assign shifted = {r, q[N-1]};
    assign trial   = shifted - {1'b0, d};
    assign r_nxt   = trial[N] ? shifted[N-1:0] : trial[N-1:0];
    assign q_nxt   = {q[N-2:0], ~trial[N]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            q            <= '0;
            d            <= '0;
            r            <= '0;
            cnt          <= '0;
            last         <= 1'b1;
            id           <= 1'b0;
            busy         <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id   <= 1'b0;
            bus.rsp_quot <= '0;
            bus.rsp_rem  <= '0;
            bus.rsp_dbz  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        q    <= acc_dividend;
                        d    <= acc_divisor;
                        r    <= '0;
                        id   <= grant;
                        last <= grant;
                        busy <= 1'b1;
                        if (acc_divisor == '0) begin
                            state         <= DONE;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_id    <= grant;
                            bus.rsp_quot  <= '1;
                            bus.rsp_rem   <= acc_dividend;
                            bus.rsp_dbz   <= 1'b1;
                        end else begin
                            state <= CALC;
                            cnt   <= '0;
                        end
                    end
                end
                CALC: begin
                    q   <= q_nxt;
                    r   <= r_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state         <= DONE;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_id    <= id;
                        bus.rsp_quot  <= q_nxt;
                        bus.rsp_rem   <= r_nxt;
                        bus.rsp_dbz   <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        busy          <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
